mips_mc_core: RTL and testbench

MIPS_MC_CORE -- requirements
Module: mips_mc_core

---
 rtl/mips_mc_core.sv | 167 ++++++++++++++++
 tb/tb_mips_mc_core.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_core.sv
// rtl/mips_mc_core.sv - multi-cycle MIPS subset core with a single shared memory port.
// One FSM state per cycle; FETCH and MEM stall until mem_ready.
module mips_mc_core #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic              halted,
  output logic [31:0]       instret
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_BEQ = 6'h04, OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D, OP_LUI = 6'h0F, OP_LW  = 6'h23, OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADDU  = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t      state, state_nx;
  logic [31:0] ir, a, b, alu_out, mdr;
  logic [31:0] rf [0:31];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, wb_idx;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] sext_imm, zext_imm, alu_res, rs_val, rt_val, wb_data;
  logic        is_r, legal, retire, beq_taken;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm16    = ir[15:0];
  assign imm26    = ir[25:0];
  assign sext_imm = {{16{imm16[15]}}, imm16};
  assign zext_imm = {16'h0000, imm16};
  assign is_r     = (op == OP_RTYPE);
  assign rs_val   = (rs == 5'd0) ? 32'h0 : rf[rs];
  assign rt_val   = (rt == 5'd0) ? 32'h0 : rf[rt];
  assign wb_idx   = is_r ? rd : rt;
  assign wb_data  = (op == OP_LW) ? mdr : alu_out;
  assign beq_taken = (a == b);

  always_comb begin
    legal = 1'b0;
    if (is_r) begin
      legal = (funct == FN_ADDU) || (funct == FN_SUBU) || (funct == FN_AND) ||
              (funct == FN_OR)   || (funct == FN_SLT);
    end else begin
      legal = (op == OP_ADDIU) || (op == OP_ORI) || (op == OP_LUI) || (op == OP_LW) ||
              (op == OP_SW)    || (op == OP_BEQ) || (op == OP_J);
    end
  end

  always_comb begin
    alu_res = 32'h0;
    if (is_r) begin
      case (funct)
        FN_ADDU: alu_res = a + b;
        FN_SUBU: alu_res = a - b;
        FN_AND:  alu_res = a & b;
        FN_OR:   alu_res = a | b;
        FN_SLT:  alu_res = {31'h0, $signed(a) < $signed(b)};
        default: alu_res = 32'h0;
      endcase
    end else begin
      case (op)
        OP_ADDIU, OP_LW, OP_SW: alu_res = a + sext_imm;
        OP_ORI:                 alu_res = a | zext_imm;
        OP_LUI:                 alu_res = {imm16, 16'h0000};
        default:                alu_res = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  state_nx = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!legal)          state_nx = S_HALT;
        else if (op == OP_J) state_nx = S_FETCH;
        else                 state_nx = S_EXEC;
      end
      S_EXEC: begin
        if (op == OP_BEQ)                     state_nx = S_FETCH;
        else if (op == OP_LW || op == OP_SW)  state_nx = S_MEM;
        else                                  state_nx = S_WB;
      end
      S_MEM: begin
        if (mem_ready) state_nx = (op == OP_SW) ? S_FETCH : S_WB;
      end
      S_WB:    state_nx = S_FETCH;
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_HALT;
    endcase
  end

  always_comb begin
    mem_req   = (state == S_FETCH) || (state == S_MEM);
    mem_we    = (state == S_MEM) && (op == OP_SW);
    mem_addr  = (state == S_FETCH) ? pc[ADDR_W+1:2] : alu_out[ADDR_W+1:2];
    mem_wdata = b;
    halted    = (state == S_HALT);
    retire    = ((state == S_DECODE) && legal && (op == OP_J)) ||
                ((state == S_EXEC) && (op == OP_BEQ)) ||
                ((state == S_MEM) && (op == OP_SW) && mem_ready) ||
                (state == S_WB);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      instret <= 32'h0;
      ir      <= 32'h0;
      a       <= 32'h0;
      b       <= 32'h0;
      alu_out <= 32'h0;
      mdr     <= 32'h0;
    end else begin
      if (retire) instret <= instret + 32'd1;
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        S_DECODE: begin
          a <= rs_val;
          b <= rt_val;
          if (legal && op == OP_J) pc <= {pc[31:28], imm26, 2'b00};
        end
        S_EXEC: begin
          alu_out <= alu_res;
          // pc already points past the branch, so the offset is relative to pc+4
          if (op == OP_BEQ && beq_taken) pc <= pc + (sext_imm << 2);
        end
        S_MEM: begin
          if (mem_ready && op == OP_LW) mdr <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Register file has no reset; r0 is never written and reads as zero through rs_val/rt_val.
  always_ff @(posedge clk) begin
    if (!rst && state == S_WB && wb_idx != 5'd0) rf[wb_idx] <= wb_data;
  end

endmodule

// File: tb/tb_mips_mc_core.sv
// tb/tb_mips_mc_core.sv - directed self-checking bench for mips_mc_core.
// Behavioural memory with programmable wait states and an optional write stall.
module tb_mips_mc_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;
  logic [31:0] pc, instret;
  logic        halted;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];
  int          wait_cycles = 0;
  int          wcnt = 0;
  int          wr_count = 0;
  int          stab_err = 0;
  bit          stall_wr = 0;
  logic [9:0]  last_waddr = '0;
  logic [31:0] last_wdata = '0;
  logic [9:0]  hold_addr = '0;
  logic [31:0] hold_wdata = '0;
  logic        hold_we = 1'b0;

  mips_mc_core #(.ADDR_W(10), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    mem_ready = mem_req && (wcnt >= wait_cycles) && !(stall_wr && mem_we);
    mem_rdata = mem[mem_addr];
    if (mem_req && wcnt > 0 &&
        (mem_addr !== hold_addr || mem_we !== hold_we || (mem_we && mem_wdata !== hold_wdata)))
      stab_err++;
    hold_addr  = mem_addr;
    hold_we    = mem_we;
    hold_wdata = mem_wdata;
  end

  always @(posedge clk) begin
    if (rst) begin
      wcnt = 0;
    end else if (mem_req && mem_ready) begin
      if (mem_we) begin
        mem[mem_addr] = mem_wdata;
        wr_count++;
        last_waddr = mem_addr;
        last_wdata = mem_wdata;
      end
      wcnt = 0;
    end else if (mem_req) begin
      wcnt++;
    end
  end

  task automatic clear_prog();
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hFC00_0000;
    wr_count = 0;
    stab_err = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_retired(input int n, input int budget, output int cyc, output bit ok);
    cyc = 0;
    ok  = 0;
    while (cyc < budget && !ok) begin
      @(posedge clk); #1;
      cyc++;
      if (instret == n) ok = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    checks++; if (instret !== 32'h0) begin errors++; $display("FAIL reset_instret: got %h expected 0", instret); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h0) begin
      errors++; $display("FAIL reset_fetch: req %b we %b addr %h expected 1 0 000", mem_req, mem_we, mem_addr);
    end
  endtask

  task automatic test_zero_wait();
    clear_prog();
    wait_cycles = 0;
    mem[0] = 32'h3401_1234;
    mem[1] = 32'h0021_1021;
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    checks++; if (instret !== 32'd1) begin errors++; $display("FAIL zw_first_latency: instret %0d expected 1", instret); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (instret !== 32'd2) begin errors++; $display("FAIL zw_instret: got %0d expected 2", instret); end
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL zw_pc: got %h expected 8", pc); end
    checks++; if (dut.rf[2] !== 32'h2468) begin errors++; $display("FAIL zw_rf2: got %h expected 2468", dut.rf[2]); end
  endtask

  task automatic test_alu();
    int cyc;
    bit ok;
    clear_prog();
    wait_cycles = 0;
    mem[0]  = 32'h3401_00F0;
    mem[1]  = 32'h3402_0FF0;
    mem[2]  = 32'h0022_1823;
    mem[3]  = 32'h0022_2024;
    mem[4]  = 32'h0022_2825;
    mem[5]  = 32'h2406_FFFE;
    mem[6]  = 32'h0022_382A;
    mem[7]  = 32'h0800_0010;
    mem[16] = 32'h3408_0007;
    do_reset();
    wait_retired(9, 200, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL alu_timeout: instret %0d expected 9", instret); end
    checks++; if (cyc !== 34) begin errors++; $display("FAIL alu_cycles: got %0d expected 34", cyc); end
    checks++; if (dut.rf[3] !== 32'hFFFF_F100) begin errors++; $display("FAIL alu_subu: got %h expected fffff100", dut.rf[3]); end
    checks++; if (dut.rf[4] !== 32'h0000_00F0) begin errors++; $display("FAIL alu_and: got %h expected 000000f0", dut.rf[4]); end
    checks++; if (dut.rf[5] !== 32'h0000_0FF0) begin errors++; $display("FAIL alu_or: got %h expected 00000ff0", dut.rf[5]); end
    checks++; if (dut.rf[6] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL alu_addiu: got %h expected fffffffe", dut.rf[6]); end
    checks++; if (dut.rf[7] !== 32'h1) begin errors++; $display("FAIL alu_slt: got %h expected 1", dut.rf[7]); end
    checks++; if (dut.rf[8] !== 32'h7 || pc !== 32'h44) begin
      errors++; $display("FAIL alu_jump: rf8 %h pc %h expected 7 44", dut.rf[8], pc);
    end
  endtask

  task automatic test_mem_waits();
    int cyc;
    bit ok;
    clear_prog();
    wait_cycles = 3;
    mem[0] = 32'h3401_1234;
    mem[1] = 32'h0021_1021;
    mem[2] = 32'hAC02_0004;
    mem[3] = 32'h8C03_0004;
    do_reset();
    wait_retired(4, 300, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mw_timeout: instret %0d expected 4", instret); end
    checks++; if (cyc !== 35) begin errors++; $display("FAIL mw_cycles: got %0d expected 35", cyc); end
    checks++; if (wr_count !== 1) begin errors++; $display("FAIL mw_write_count: got %0d expected 1", wr_count); end
    checks++; if (last_waddr !== 10'd1 || last_wdata !== 32'h2468) begin
      errors++; $display("FAIL mw_write: addr %h data %h expected 001 00002468", last_waddr, last_wdata);
    end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL mw_stability: %0d changes expected 0", stab_err); end
    checks++; if (dut.rf[3] !== 32'h2468) begin errors++; $display("FAIL mw_lw: got %h expected 2468", dut.rf[3]); end
    wait_cycles = 0;
  endtask

  task automatic test_beq();
    clear_prog();
    wait_cycles = 0;
    mem[0] = 32'h1000_FFFF;
    do_reset();
    @(posedge clk); #1;
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL beq_fetch_pc: got %h expected 4", pc); end
    repeat (2) @(posedge clk); #1;
    checks++; if (pc !== 32'h0 || instret !== 32'd1) begin
      errors++; $display("FAIL beq_loop1: pc %h instret %0d expected 0 1", pc, instret);
    end
    repeat (3) @(posedge clk); #1;
    checks++; if (pc !== 32'h0 || instret !== 32'd2) begin
      errors++; $display("FAIL beq_loop2: pc %h instret %0d expected 0 2", pc, instret);
    end
    clear_prog();
    mem[0] = 32'h3401_0001;
    mem[1] = 32'h1020_0005;
    mem[2] = 32'h3406_0055;
    do_reset();
    repeat (7) @(posedge clk); #1;
    checks++; if (pc !== 32'h8 || instret !== 32'd2) begin
      errors++; $display("FAIL beq_fallthrough: pc %h instret %0d expected 8 2", pc, instret);
    end
    repeat (4) @(posedge clk); #1;
    checks++; if (dut.rf[6] !== 32'h55 || instret !== 32'd3) begin
      errors++; $display("FAIL beq_next: rf6 %h instret %0d expected 55 3", dut.rf[6], instret);
    end
  endtask

  task automatic test_lui_slt_r0();
    int cyc;
    bit ok;
    clear_prog();
    wait_cycles = 0;
    mem[0] = 32'h3C04_FFFF;
    mem[1] = 32'h0080_282A;
    mem[2] = 32'h0084_0021;
    mem[3] = 32'hAC00_0008;
    do_reset();
    wait_retired(4, 100, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL lui_timeout: instret %0d expected 4", instret); end
    checks++; if (dut.rf[4] !== 32'hFFFF_0000) begin errors++; $display("FAIL lui_value: got %h expected ffff0000", dut.rf[4]); end
    checks++; if (dut.rf[5] !== 32'h1) begin errors++; $display("FAIL slt_signed: got %h expected 1", dut.rf[5]); end
    checks++; if (wr_count !== 1 || last_waddr !== 10'd2 || last_wdata !== 32'h0) begin
      errors++; $display("FAIL r0_zero: writes %0d addr %h data %h expected 1 002 0", wr_count, last_waddr, last_wdata);
    end
  endtask

  task automatic test_illegal();
    int cyc;
    bit ok;
    bit req_seen;
    clear_prog();
    wait_cycles = 0;
    mem[0] = 32'h3401_0001;
    do_reset();
    wait_retired(1, 50, cyc, ok);
    repeat (2) @(posedge clk); #1;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL ill_halted: got %b expected 1", halted); end
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (mem_req !== 1'b0 || halted !== 1'b1) req_seen = 1;
    end
    checks++; if (req_seen) begin errors++; $display("FAIL ill_quiet: req or halted changed, got 1 expected 0"); end
    checks++; if (instret !== 32'd1 || pc !== 32'h8) begin
      errors++; $display("FAIL ill_frozen: instret %0d pc %h expected 1 8", instret, pc);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 10'h0 || pc !== 32'h0) begin
      errors++; $display("FAIL ill_reset: halted %b req %b addr %h pc %h expected 0 1 000 0", halted, mem_req, mem_addr, pc);
    end
    rst = 1'b0;
    clear_prog();
    mem[0] = 32'h0000_0020;
    do_reset();
    repeat (4) @(posedge clk); #1;
    checks++; if (halted !== 1'b1 || instret !== 32'd0) begin
      errors++; $display("FAIL ill_funct: halted %b instret %0d expected 1 0", halted, instret);
    end
  endtask

  task automatic test_reset_during_sw();
    int  cyc;
    clear_prog();
    wait_cycles = 0;
    stall_wr = 1;
    mem[0] = 32'hAC00_0004;
    do_reset();
    cyc = 0;
    while (cyc < 20 && mem_we !== 1'b1) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (mem_we !== 1'b1 || cyc !== 3) begin
      errors++; $display("FAIL sw_reach_mem: we %b after %0d cycles expected 1 after 3", mem_we, cyc);
    end
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h0) begin
      errors++; $display("FAIL sw_abandon: req %b we %b addr %h expected 1 0 000", mem_req, mem_we, mem_addr);
    end
    checks++; if (wr_count !== 0) begin errors++; $display("FAIL sw_no_write: got %0d writes expected 0", wr_count); end
    rst = 1'b0;
    stall_wr = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hFC00_0000;
    test_reset();
    test_zero_wait();
    test_alu();
    test_mem_waits();
    test_beq();
    test_lui_slt_r0();
    test_illegal();
    test_reset_during_sw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
